// File: rtl/aes_io_pkg.sv
// Shared types and widths for the AES result path between the core-side
// writer and the host-side serializer.
package aes_io_pkg;

  localparam int TAG_W   = 2;
  localparam int DATA_W  = 128;
  localparam int BEAT_W  = 32;
  localparam int NBEATS  = 1 + DATA_W / BEAT_W;
  localparam int ENTRY_W = TAG_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND
  } out_state_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] block;
  } aes_result_t;

endpackage

// File: rtl/aes_out_serializer.sv
// Pops AES result entries from the output FIFO and streams each one to the
// host as a 5-beat valid/ready packet: tag word first, then the block MSW first.
//
// state | meaning
// IDLE  | nothing held; pop as soon as the FIFO is non-empty
// FETCH | FIFO read data valid; capture into the holding register
// SEND  | present beats 0..4; on the last handshake prefetch or go idle
module aes_out_serializer
  import aes_io_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               fifo_empty,
  output logic               fifo_rd_en,
  input  logic [ENTRY_W-1:0] fifo_dout,
  output logic [BEAT_W-1:0]  m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               busy
);

  localparam logic [2:0] LAST_BEAT = 3'(NBEATS - 1);

  out_state_t        state_q, state_d;
  logic [2:0]        beat_q, beat_d;
  aes_result_t       hold_q, hold_d;
  logic [BEAT_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    hold_d     = hold_q;
    fifo_rd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd_en = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        hold_d  = aes_result_t'(fifo_dout);
        beat_d  = 3'd0;
        state_d = SEND;
      end
      SEND: begin
        if (m_ready) begin
          if (beat_q == LAST_BEAT) begin
            beat_d = 3'd0;
            // Prefetch in the last-handshake cycle keeps the gap to one FETCH bubble.
            if (!fifo_empty) begin
              fifo_rd_en = 1'b1;
              state_d    = FETCH;
            end else begin
              state_d = IDLE;
            end
          end else begin
            beat_d = beat_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) fifo_rd_en = 1'b0;
  end

  // Outputs are registered from next-state values so they line up with state_q.
  always_comb begin
    m_valid_d = (state_d == SEND);
    m_last_d  = (state_d == SEND) && (beat_d == LAST_BEAT);
    busy_d    = (state_d != IDLE);
    case (beat_d)
      3'd0:    m_data_d = {{(BEAT_W-TAG_W){1'b0}}, hold_d.tag};
      3'd1:    m_data_d = hold_d.block[127:96];
      3'd2:    m_data_d = hold_d.block[95:64];
      3'd3:    m_data_d = hold_d.block[63:32];
      3'd4:    m_data_d = hold_d.block[31:0];
      default: m_data_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      beat_q    <= 3'd0;
      hold_q    <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      hold_q    <= hold_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      busy_q    <= busy_d;
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;
  assign busy    = busy_q;

  a_beat_range: assert property (@(posedge clk) disable iff (rst) beat_q <= LAST_BEAT);

endmodule

// File: tb/tb_aes_out_serializer.sv
// Self-checking bench: a queue-based FIFO model feeds the serializer and a
// packet-level reference model predicts pops, beats, valid, last and busy.
module tb_aes_out_serializer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [129:0] fifo_dout = '0;
  logic [31:0]  m_data;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic         busy;

  aes_out_serializer dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural FIFO: registered empty flag, read data one cycle after pop.
  logic [129:0] fq[$];
  logic         push_valid = 1'b0;
  logic [129:0] push_data  = '0;

  always @(posedge clk) begin
    if (rst) begin
      fq.delete();
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (push_valid && fq.size() < 32) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  function automatic logic [31:0] ref_beat(input logic [1:0] tag, input logic [127:0] blk, input int i);
    if (i == 0) return {30'd0, tag};
    return 32'(blk >> (32 * (4 - i)));
  endfunction

  // Packet-level reference model, evaluated mid-cycle.
  logic [31:0] exp_q[$];
  logic [31:0] obs_q[$];
  logic        in_packet = 1'b0;
  logic        fetch = 1'b0;
  int          beat_idx = 0;
  int          pop_cnt = 0;
  int          hs_cnt = 0;

  always @(negedge clk) begin
    logic        exp_rd;
    logic [31:0] exp_beat;
    if (rst) begin
      chk("rd_in_reset", 64'(fifo_rd_en), 64'd0);
      in_packet = 1'b0;
      fetch     = 1'b0;
      beat_idx  = 0;
      exp_q.delete();
    end else begin
      exp_rd = !fifo_empty &&
               ((!in_packet && !fetch) || (in_packet && beat_idx == 4 && m_ready));
      chk("rd_en", 64'(fifo_rd_en), 64'(exp_rd));
      chk("m_valid", 64'(m_valid), 64'(in_packet));
      chk("busy", 64'(busy), 64'(in_packet || fetch));
      if (in_packet) begin
        exp_beat = (exp_q.size() > 0) ? exp_q[0] : 32'hxxxx_xxxx;
        chk("m_last", 64'(m_last), 64'(beat_idx == 4));
        chk("m_data", 64'(m_data), 64'(exp_beat));
        if (m_ready) begin
          obs_q.push_back(m_data);
          hs_cnt++;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      if (fifo_rd_en) pop_cnt++;
      if (fetch) begin
        in_packet = 1'b1;
        beat_idx  = 0;
      end else if (in_packet && m_ready) begin
        if (beat_idx == 4) begin
          in_packet = 1'b0;
          beat_idx  = 0;
        end else begin
          beat_idx++;
        end
      end
      fetch = exp_rd;
    end
  end

  int rdy_mode = 0;  // 0: low, 1: high, 2: random 30%, 3: left to caller

  task automatic step();
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: m_ready = 1'b0;
      1: m_ready = 1'b1;
      2: m_ready = ($urandom_range(0, 99) < 30);
      default: ;
    endcase
  endtask

  task automatic push(input logic [1:0] tag, input logic [127:0] blk);
    push_valid = 1'b1;
    push_data  = {tag, blk};
    for (int i = 0; i < 5; i++) exp_q.push_back(ref_beat(tag, blk, i));
    step();
    push_valid = 1'b0;
  endtask

  task automatic push_rand();
    push(2'($urandom_range(0, 3)), {$urandom, $urandom, $urandom, $urandom});
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || in_packet || fetch || fq.size() != 0) && n < budget) begin
      step();
      n++;
    end
    chk(tag, 64'(n < budget), 64'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_last"}, 64'(m_last), 64'd0);
    chk({tag, "_m_data"}, 64'(m_data), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_rd_en"}, 64'(fifo_rd_en), 64'd0);
  endtask

  initial begin
    logic [31:0] lit[5];
    int p0, h0, n;

    lit[0] = 32'h0000_0001;
    lit[1] = 32'h0011_2233;
    lit[2] = 32'h4455_6677;
    lit[3] = 32'h8899_AABB;
    lit[4] = 32'hCCDD_EEFF;

    // Reset values
    rst = 1'b1;
    repeat (3) step();
    check_idle_outputs("reset");
    rst = 1'b0;

    // Empty FIFO for 20 cycles
    for (int i = 0; i < 20; i++) begin
      step();
      chk("empty_rd_en", 64'(fifo_rd_en), 64'd0);
      chk("empty_m_valid", 64'(m_valid), 64'd0);
      chk("empty_busy", 64'(busy), 64'd0);
    end

    // Single entry, m_ready high
    rdy_mode = 1;
    step();
    obs_q.delete();
    p0 = pop_cnt;
    h0 = hs_cnt;
    push(2'b01, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    wait_drain("single_timeout", 40);
    chk("single_pops", 64'(pop_cnt - p0), 64'd1);
    chk("single_beats", 64'(hs_cnt - h0), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("single_beat_val", 64'((obs_q.size() > i) ? obs_q[i] : 32'hxxxx_xxxx), 64'(lit[i]));

    // Back-to-back, 3 entries
    repeat (3) step();
    p0 = pop_cnt;
    h0 = hs_cnt;
    repeat (3) push_rand();
    wait_drain("b2b_timeout", 60);
    chk("b2b_pops", 64'(pop_cnt - p0), 64'd3);
    chk("b2b_beats", 64'(hs_cnt - h0), 64'd15);

    // Backpressure with 30% ready duty and a full FIFO behind the held entry
    rdy_mode = 0;
    repeat (3) step();
    p0 = pop_cnt;
    h0 = hs_cnt;
    repeat (32) push_rand();
    rdy_mode = 2;
    wait_drain("bp_timeout", 3000);
    chk("bp_pops", 64'(pop_cnt - p0), 64'd32);
    chk("bp_beats", 64'(hs_cnt - h0), 64'd160);

    // Reset after beat 2 is accepted
    rdy_mode = 3;
    m_ready  = 1'b0;
    repeat (3) step();
    push_rand();
    n = 0;
    while (!m_valid && n < 20) begin
      step();
      n++;
    end
    chk("rst_wait_valid", 64'(m_valid), 64'd1);
    m_ready = 1'b1;
    repeat (3) step();
    m_ready = 1'b0;
    rst     = 1'b1;
    step();
    rst     = 1'b0;
    check_idle_outputs("midrst");
    rdy_mode = 1;
    step();
    obs_q.delete();
    h0 = hs_cnt;
    push(2'b10, 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98);
    wait_drain("post_rst_timeout", 40);
    chk("post_rst_beats", 64'(hs_cnt - h0), 64'd5);
    chk("post_rst_beat0", 64'((obs_q.size() > 0) ? obs_q[0] : 32'hxxxx_xxxx), 64'h2);
    chk("post_rst_beat4", 64'((obs_q.size() > 4) ? obs_q[4] : 32'hxxxx_xxxx), 64'hFEDCBA98);

    // Full drain: fill while stalled, then release m_ready
    rdy_mode = 0;
    repeat (3) step();
    p0 = pop_cnt;
    h0 = hs_cnt;
    repeat (32) push_rand();
    rdy_mode = 1;
    wait_drain("drain_timeout", 400);
    repeat (10) step();
    chk("drain_pops", 64'(pop_cnt - p0), 64'd32);
    chk("drain_beats", 64'(hs_cnt - h0), 64'd160);
    chk("drain_empty", 64'(fifo_empty), 64'd1);
    chk("drain_busy", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/aes_out_serializer.md
# aes_out_serializer

Drain side of the AES output FIFO: pops 130-bit result entries ({tag[1:0], block[127:0]}) from the FIFO read port and streams each one to the host as a 5-beat, 32-bit valid/ready packet. It sits between the output buffer's `fifo` instance (DEPTH 32, WIDTH 130) and the host-facing read bus. It is the reader for the accelerator core, which writes results into the output buffer.

## Interface
- `TAG_W`, 2: tag bits carried in entry bits [129:128].
- `DATA_W`, 128: AES block bits carried in entry bits [127:0].
- `BEAT_W`, 32: host beat width. `NBEATS` = 1 + DATA_W/BEAT_W = 5 (derived, not overridable).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_rd_en` out 1: FIFO pop request; a one-cycle pulse.
- `fifo_dout` in TAG_W+DATA_W: FIFO read data, valid the cycle after `fifo_rd_en`.
- `m_data` out BEAT_W: host beat data.
- `m_valid` out 1: beat valid.
- `m_ready` in 1: host accepts the beat.
- `m_last` out 1: high on the final (5th) beat of a packet.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states:
  - IDLE: if `!fifo_empty`, assert `fifo_rd_en` this cycle and go to FETCH; otherwise stay.
  - FETCH: `fifo_dout` is valid this cycle. Capture it into a 130-bit holding register, clear the beat counter, and go to SEND.
  - SEND: `m_valid`=1. On `m_valid && m_ready`, increment `beat`. On the handshake of beat 4:
    - if `!fifo_empty`, assert `fifo_rd_en` in that same cycle and go to FETCH (back-to-back prefetch);
    - otherwise go to IDLE.
- Beat mapping, selected by the 3-bit `beat` counter from the holding register:
  - beat 0 = {30'b0, tag}
  - beat 1 = block[127:96]
  - beat 2 = block[95:64]
  - beat 3 = block[63:32]
  - beat 4 = block[31:0]
- `m_last` = (state==SEND && beat==4).
- Hold rule: while `m_valid && !m_ready`, `m_data` and `m_last` are stable and `beat` does not advance.
- `fifo_rd_en` is never asserted when `fifo_empty`=1, in FETCH, in SEND before the last handshake, or during reset.
- At most one entry is in flight. No pop occurs while the holding register contains an unsent beat.
- Counter: `beat` is 3 bits and takes values 0..4 only. Values 5..7 are unreachable and must be covered by an assertion.

## Timing
- Reset values: state=IDLE, `beat`=0, holding register=0, `fifo_rd_en`=0, `m_valid`=0, `m_last`=0, `m_data`=0, `busy`=0.
- Latency:
  - `fifo_empty` observed low in IDLE at cycle N gives `fifo_rd_en`=1 at N and `m_valid`=1 with beat 0 at N+2.
  - With `m_ready` held high, a packet occupies cycles N+2..N+6.
- Throughput:
  - Back-to-back entries with `m_ready`=1 take 6 cycles per entry: 5 beats plus 1 FETCH bubble.
  - From IDLE, the first entry takes 7 cycles.
- Simultaneous events: a FIFO write that arrives during the last-beat handshake cycle is seen only if `fifo_empty` is already low in that cycle. Otherwise the entry is picked up from IDLE on the next cycle.
- `m_ready` may toggle on any cycle. `m_valid` never drops before a handshake.
- Reset mid-packet (synchronous): the next edge returns the FSM to IDLE and `m_valid` goes to 0. The partially sent entry is discarded (it was already popped). The FIFO is reset by the same `rst`.

## Structure
- Shared package `aes_io_pkg` holds:
  - TAG_W, DATA_W, BEAT_W, NBEATS;
  - the `out_state_t` enum {IDLE, FETCH, SEND};
  - the `aes_result_t` packed struct {tag, block}, also used by the writer side.
- No sub-module is required. The beat mux is an inline case on `beat`.
- Top-level integration instantiates `fifo` directly, with `empty` connected to this block.

## Test plan
- **Single entry.** Push {2'b01, 128'h00112233_44556677_8899AABB_CCDDEEFF} with `m_ready`=1.
  - Required: beats 0x00000001, 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF.
  - `m_last` high only on the 5th beat; first `m_valid` 2 cycles after the pop.
- **Back-to-back.** Push 3 entries with `m_ready`=1.
  - Required: 15 beats in order and exactly 3 `fifo_rd_en` pulses.
  - The 2nd pop occurs in the same cycle as the 1st packet's `m_last` handshake; exactly 1 idle cycle between packets.
- **Backpressure.** Apply a random `m_ready` duty of 30%.
  - Required: `m_data`/`m_last` stable while stalled and the beat order is unchanged.
  - No `fifo_rd_en` occurs mid-packet, even with the FIFO holding 31 more entries.
- **Empty FIFO.** Hold `fifo_empty`=1 for 20 cycles.
  - Required: `fifo_rd_en`=0, `m_valid`=0, `busy`=0 throughout.
- **Reset mid-packet.** Assert `rst` for 1 cycle after beat 2 is accepted.
  - Required: `m_valid`=0 on the next cycle and all outputs at reset values.
  - A fresh push afterwards produces a clean 5-beat packet starting at beat 0.
- **FIFO full drain.** Fill 32 entries, then release `m_ready`=1.
  - Required: 160 beats, and `fifo_empty` asserts after the 32nd pop with no extra `fifo_rd_en`.
